// File: rtl/crc32_8_chk.sv
// Receive-side CRC-32 checker: byte-parallel CRC over sof..eof, residue compare,
// and a 4-byte delay line that strips the trailing FCS from the forwarded payload.
module crc32_8_chk #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  d,
    input  logic        d_valid,
    input  logic        sof,
    input  logic        eof,
    output logic [7:0]  q,
    output logic        q_valid,
    output logic        q_sof,
    output logic        q_eof,
    output logic        done,
    output logic        fcs_ok,
    output logic        len_err,
    output logic        aborted,
    output logic [15:0] frame_len,
    output logic [31:0] crc_reg
);

    // state | meaning
    // IDLE  | waiting for sof; other bytes are ignored
    // RUN   | inside a frame; accepting bytes until eof or a new sof

    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hC704_DD7B;
    localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        abort;
    logic        fin;
    logic        push_out;
    logic [31:0] crc_base;
    logic [31:0] crc_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_base;
    logic [15:0] cnt_inc;
    logic [7:0]  dl [4];
    logic [2:0]  fill;
    logic        first_pend;

    // MSB-first update, identical bit ordering to the transmit generator
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ b[i];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A sof+eof byte arriving mid-frame reports the abort; the single-byte
    // frame it would open cannot get its own done pulse and is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (d_valid && sof && !eof) state_nxt = RUN;
            RUN:  if (d_valid && eof)         state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept   = d_valid && ((state == RUN) || sof);
        abort    = d_valid && sof && (state == RUN);
        fin      = accept && eof && !abort;
        push_out = accept && !sof && (fill == 3'd4);
    end

    always_comb begin
        crc_base = sof ? INIT : crc_reg;
        crc_nxt  = crc_step(crc_base, d);
        cnt_base = sof ? 16'd0 : cnt;
        cnt_inc  = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_reg    <= INIT;
            cnt        <= 16'd0;
            fill       <= 3'd0;
            first_pend <= 1'b0;
            dl[0]      <= 8'h00;
            dl[1]      <= 8'h00;
            dl[2]      <= 8'h00;
            dl[3]      <= 8'h00;
        end else if (accept) begin
            crc_reg <= crc_nxt;
            cnt     <= cnt_inc;
            dl[0]   <= d;
            dl[1]   <= dl[0];
            dl[2]   <= dl[1];
            dl[3]   <= dl[2];
            if (eof) begin
                fill <= 3'd0;
            end else if (sof) begin
                fill <= 3'd1;
            end else if (fill != 3'd4) begin
                fill <= fill + 3'd1;
            end
            if (sof) begin
                first_pend <= 1'b1;
            end else if (push_out) begin
                first_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q       <= 8'h00;
            q_valid <= 1'b0;
            q_sof   <= 1'b0;
            q_eof   <= 1'b0;
        end else begin
            q_valid <= push_out;
            q_sof   <= push_out && first_pend;
            q_eof   <= push_out && eof;
            if (push_out) begin
                q <= dl[3];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done      <= 1'b0;
            fcs_ok    <= 1'b0;
            len_err   <= 1'b0;
            aborted   <= 1'b0;
            frame_len <= 16'd0;
        end else begin
            done <= fin || abort;
            if (abort) begin
                fcs_ok    <= 1'b0;
                len_err   <= 1'b0;
                aborted   <= 1'b1;
                frame_len <= cnt;
            end else if (fin) begin
                fcs_ok    <= (crc_nxt == RESIDUE);
                len_err   <= (cnt_inc < MIN_L) || (cnt_inc > MAX_L);
                aborted   <= 1'b0;
                frame_len <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_crc32_8_chk.sv
// Directed bench for crc32_8_chk: frames with bench-computed FCS, runts, giant,
// abort and mid-frame reset, checked with immediate assertions.
module tb_crc32_8_chk;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        d_valid = 1'b0;
    logic        sof = 1'b0;
    logic        eof = 1'b0;
    logic [7:0]  q;
    logic        q_valid;
    logic        q_sof;
    logic        q_eof;
    logic        done;
    logic        fcs_ok;
    logic        len_err;
    logic        aborted;
    logic [15:0] frame_len;
    logic [31:0] crc_reg;

    crc32_8_chk #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid), .sof(sof), .eof(eof),
        .q(q), .q_valid(q_valid), .q_sof(q_sof), .q_eof(q_eof), .done(done),
        .fcs_ok(fcs_ok), .len_err(len_err), .aborted(aborted),
        .frame_len(frame_len), .crc_reg(crc_reg)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  frm[$];
    logic [7:0]  rx[$];
    logic [31:0] tbl[256];
    int          sof_cnt = 0;
    int          sof_idx = -1;
    int          eof_cnt = 0;
    int          sof_eof_same = 0;
    int          done_cnt = 0;
    int          done_before;

    always @(negedge clk) begin
        if (q_valid) begin
            rx.push_back(q);
            if (q_sof) begin
                sof_cnt++;
                sof_idx = rx.size() - 1;
            end
            if (q_eof) eof_cnt++;
            if (q_sof && q_eof) sof_eof_same++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rx.delete();
        sof_cnt = 0;
        sof_idx = -1;
        eof_cnt = 0;
        sof_eof_same = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic s, input logic e);
        d = b; d_valid = 1'b1; sof = s; eof = e;
        @(posedge clk);
        #1;
        d = 8'h00; d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    endtask

    task automatic send(input int gap, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            drive(frm[i], i == 0, i == frm.size() - 1);
            if (gap != 0 && i != upto - 1) idle(1);
        end
    endtask

    // payload byte i = i mod 256, then ~crc appended MSB byte first
    task automatic build(input int npay, input int flip);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        frm.delete();
        for (int i = 0; i < npay; i++) begin
            b = i[7:0];
            frm.push_back(b);
            c = {c[23:0], 8'h00} ^ tbl[c[31:24] ^ b];
        end
        c = ~c;
        frm.push_back(c[31:24]);
        frm.push_back(c[23:16]);
        frm.push_back(c[15:8]);
        frm.push_back(c[7:0]);
        if (flip >= 0) frm[flip] = frm[flip] ^ 8'h01;
    endtask

    task automatic chk_status(input string tag, input logic ok, input logic le,
                              input logic [15:0] len, input logic ab);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".fcs_ok"}, {31'd0, fcs_ok}, {31'd0, ok});
        chk({tag, ".len_err"}, {31'd0, len_err}, {31'd0, le});
        chk({tag, ".frame_len"}, {16'd0, frame_len}, {16'd0, len});
        chk({tag, ".aborted"}, {31'd0, aborted}, {31'd0, ab});
    endtask

    task automatic chk_payload(input string tag, input int n);
        int bad;
        bad = 0;
        chk({tag, ".q_count"}, rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++) begin
            if (rx[i] !== frm[i]) bad++;
        end
        chk({tag, ".q_bytes_wrong"}, bad, 0);
    endtask

    initial begin
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = {i[7:0], 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ({c[30:0], 1'b0} ^ 32'h04C1_1DB7) : {c[30:0], 1'b0};
            tbl[i] = c;
        end

        idle(2);
        chk("rst.crc_reg", crc_reg, 32'hFFFF_FFFF);
        chk("rst.outs", {q, q_valid, q_sof, q_eof, done, fcs_ok, len_err, aborted, frame_len}, 32'd0);
        reset_n = 1'b1;
        idle(1);

        drive(8'h55, 1'b0, 1'b0);
        chk("idle_ignore.crc_reg", crc_reg, 32'hFFFF_FFFF);
        chk("idle_ignore.done", {31'd0, done}, 32'd0);

        // good 64-byte frame
        clr();
        build(60, -1);
        send(0, 0, frm.size());
        chk_status("good", 1'b1, 1'b0, 16'd64, 1'b0);
        chk("good.crc_reg", crc_reg, 32'hC704_DD7B);
        chk("good.q_eof_at_done", {31'd0, q_eof}, 32'd1);
        idle(1);
        chk_payload("good", 60);
        chk("good.sof_idx", sof_idx, 0);
        chk("good.sof_cnt", sof_cnt, 1);
        chk("good.eof_cnt", eof_cnt, 1);
        idle(3);
        chk("hold.done", {31'd0, done}, 32'd0);
        chk("hold.fcs_ok", {31'd0, fcs_ok}, 32'd1);
        chk("hold.frame_len", {16'd0, frame_len}, 32'd64);

        // corrupted byte 10
        clr();
        build(60, 10);
        send(0, 0, frm.size());
        chk_status("bad", 1'b0, 1'b0, 16'd64, 1'b0);
        idle(1);
        chk_payload("bad", 60);
        chk("bad.byte10", {24'd0, rx[10]}, 32'h0B);

        // d_valid low every other cycle
        clr();
        build(60, -1);
        send(1, 0, frm.size());
        chk_status("gap", 1'b1, 1'b0, 16'd64, 1'b0);
        chk("gap.q_eof_at_done", {31'd0, q_eof}, 32'd1);
        idle(1);
        chk_payload("gap", 60);
        chk("gap.eof_cnt", eof_cnt, 1);

        // 32-byte runt
        clr();
        build(28, -1);
        send(0, 0, frm.size());
        chk_status("runt32", 1'b1, 1'b1, 16'd32, 1'b0);
        idle(1);
        chk_payload("runt32", 28);

        // 1-byte frame
        clr();
        frm.delete();
        frm.push_back(8'hA5);
        done_before = done_cnt;
        send(0, 0, 1);
        chk("runt1.done", {31'd0, done}, 32'd1);
        chk("runt1.len_err", {31'd0, len_err}, 32'd1);
        chk("runt1.frame_len", {16'd0, frame_len}, 32'd1);
        idle(1);
        chk("runt1.q_count", rx.size(), 0);
        chk("runt1.done_cnt", done_cnt - done_before, 1);

        // 5-byte frame: single payload byte carries both q_sof and q_eof
        clr();
        build(1, -1);
        send(0, 0, frm.size());
        chk_status("n5", 1'b1, 1'b1, 16'd5, 1'b0);
        idle(1);
        chk_payload("n5", 1);
        chk("n5.sof_eof_same", sof_eof_same, 1);

        // "123456789": known CRC-32/BZIP2 check value 0xFC891918, register holds its complement
        clr();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        send(0, 0, 9);
        chk_status("ascii9", 1'b0, 1'b1, 16'd9, 1'b0);
        chk("ascii9.crc_reg", crc_reg, 32'h0376_E6E7);
        idle(1);
        chk_payload("ascii9", 5);

        // giant
        clr();
        build(1515, -1);
        send(0, 0, frm.size());
        chk_status("giant", 1'b1, 1'b1, 16'd1519, 1'b0);
        idle(1);
        chk_payload("giant", 1515);

        // abort at byte 20
        clr();
        build(60, -1);
        send(0, 0, 20);
        idle(1);
        chk_payload("pre_abort", 16);
        chk("pre_abort.eof_cnt", eof_cnt, 0);
        clr();
        build(60, -1);
        send(0, 0, 1);
        chk_status("abort", 1'b0, 1'b0, 16'd20, 1'b1);
        send(0, 1, frm.size());
        chk_status("after_abort", 1'b1, 1'b0, 16'd64, 1'b0);
        idle(1);
        chk_payload("after_abort", 60);
        chk("after_abort.eof_cnt", eof_cnt, 1);

        // reset mid-frame
        build(60, -1);
        send(0, 0, 30);
        done_before = done_cnt;
        reset_n = 1'b0;
        idle(2);
        chk("midrst.frame_len", {16'd0, frame_len}, 32'd0);
        chk("midrst.crc_reg", crc_reg, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        idle(2);
        chk("midrst.no_done", done_cnt - done_before, 0);
        clr();
        send(0, 0, frm.size());
        chk_status("post_rst", 1'b1, 1'b0, 16'd64, 1'b0);
        idle(1);
        chk_payload("post_rst", 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
